// File: rtl/gcd_requester.sv
// -----------------------------------------------------------------------------
// gcd_requester
// Front-end sequencer that takes a user GCD request and drives an external
// subtract-based GCD core through its idle/start/run/ack handshake.
//
// Optional feature macro: GCD_REQ_TIMEOUT_EN
//   When defined, RUN counts CEN pulses and aborts the request after
//   TIMEOUT_STEPS pulses without Core_Done. The abort pulses Core_Reset,
//   returns Result=0 and raises Err.
//
// Parameters
//   STEP_DIV       core step period in clock cycles (1..255)
//   TIMEOUT_STEPS  CEN pulses allowed in RUN before abort (macro builds only)
//
// Ports
//   i_clk           clock, all state on rising edge
//   i_rst_n         asynchronous active-low reset
//   i_req           user request, sampled in IDLE only
//   i_x_in/i_y_in   operands, captured when the request is accepted
//   o_busy          high in every state except IDLE
//   o_result        last GCD, held until the next completion
//   o_result_valid  one-cycle pulse per completed request
//   o_err           sticky error, cleared by the next accepted request
//   o_start/o_ack/o_cen/o_core_reset   core control (core reset active-high)
//   o_ain/o_bin     core operands
//   i_core_i/i_core_done/i_core_gcd    core status and result
// -----------------------------------------------------------------------------
module gcd_requester #(
    parameter int unsigned STEP_DIV      = 1,
    parameter int unsigned TIMEOUT_STEPS = 1023,
    localparam int unsigned DATA_W       = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_x_in,
    input  logic [DATA_W-1:0] i_y_in,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_result,
    output logic              o_result_valid,
    output logic              o_err,
    output logic              o_start,
    output logic              o_ack,
    output logic              o_cen,
    output logic              o_core_reset,
    output logic [DATA_W-1:0] o_ain,
    output logic [DATA_W-1:0] o_bin,
    input  logic              i_core_i,
    input  logic              i_core_done,
    input  logic [DATA_W-1:0] i_core_gcd
);

    localparam int unsigned DIV_W = 8;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    // Elaboration-time parameter sanity checks
    if (STEP_DIV == 0 || STEP_DIV > 255) begin : g_bad_step_div
        $error("gcd_requester: STEP_DIV must be in 1..255");
    end
    if (TIMEOUT_STEPS == 0) begin : g_bad_timeout
        $error("gcd_requester: TIMEOUT_STEPS must be at least 1");
    end

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_ARM   = 5'b00010,
        S_START = 5'b00100,
        S_RUN   = 5'b01000,
        S_ACK   = 5'b10000
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_ain;
    logic [DATA_W-1:0] r_bin;
    logic [DATA_W-1:0] r_result;
    logic              r_result_valid;
    logic              r_err;
    logic              r_start;
    logic              r_ack;
    logic              r_cen;
    logic              r_core_reset;
    logic [DIV_W-1:0]  r_div;

    logic [DIV_W-1:0]  w_div_next;
    logic              w_timeout;

    // Step divider: CEN is high in the cycle where the divider sits at its last count
    assign w_div_next = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);

`ifdef GCD_REQ_TIMEOUT_EN
    localparam int unsigned STEPS_W = $clog2(TIMEOUT_STEPS + 1);
    localparam logic [STEPS_W-1:0] STEPS_LAST = STEPS_W'(TIMEOUT_STEPS - 1);

    logic [STEPS_W-1:0] r_steps;

    // Counts CEN pulses issued in RUN; held at zero outside RUN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_steps <= '0;
        end else if (r_state != S_RUN) begin
            r_steps <= '0;
        end else if (r_cen) begin
            r_steps <= r_steps + STEPS_W'(1);
        end
    end

    // Abort on the edge that closes the last permitted CEN pulse
    assign w_timeout = r_cen && (r_steps == STEPS_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // Request sequencer and all registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_ain          <= '0;
            r_bin          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
            r_start        <= 1'b0;
            r_ack          <= 1'b0;
            r_cen          <= 1'b0;
            r_core_reset   <= 1'b1;
            r_div          <= '0;
        end else begin
            r_result_valid <= 1'b0;
            r_core_reset   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        if (i_x_in != '0 && i_y_in != '0) begin
                            r_ain   <= i_x_in;
                            r_bin   <= i_y_in;
                            r_err   <= 1'b0;
                            r_state <= S_ARM;
                        end else begin
                            // gcd(a,0)=a: answer locally without touching the core
                            r_result       <= i_x_in | i_y_in;
                            r_result_valid <= 1'b1;
                            r_err          <= (i_x_in == '0) && (i_y_in == '0);
                        end
                    end
                end
                S_ARM: begin
                    if (i_core_i) begin
                        r_start <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (!i_core_i) begin
                        r_start <= 1'b0;
                        r_div   <= '0;
                        r_cen   <= (DIV_LAST == '0);
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_core_done) begin
                        r_result <= i_core_gcd;
                        r_cen    <= 1'b0;
                        r_ack    <= 1'b1;
                        r_state  <= S_ACK;
                    end else if (w_timeout) begin
                        r_result       <= '0;
                        r_err          <= 1'b1;
                        r_result_valid <= 1'b1;
                        r_core_reset   <= 1'b1;
                        r_cen          <= 1'b0;
                        r_state        <= S_IDLE;
                    end else begin
                        r_div <= w_div_next;
                        r_cen <= (w_div_next == DIV_LAST);
                    end
                end
                S_ACK: begin
                    if (i_core_i) begin
                        r_ack          <= 1'b0;
                        r_result_valid <= 1'b1;
                        r_state        <= S_IDLE;
                    end
                end
                default: begin
                    // Corrupted one-hot encoding: drop core controls and recover
                    r_start <= 1'b0;
                    r_ack   <= 1'b0;
                    r_cen   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy         = (r_state != S_IDLE);
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_err          = r_err;
    assign o_start        = r_start;
    assign o_ack          = r_ack;
    assign o_cen          = r_cen;
    assign o_core_reset   = r_core_reset;
    assign o_ain          = r_ain;
    assign o_bin          = r_bin;

endmodule

// File: tb/tb_gcd_requester.sv
// -----------------------------------------------------------------------------
// tb_gcd_requester
// Directed bench for gcd_requester. Instance 0 runs STEP_DIV=1 (TIMEOUT_STEPS=8),
// instance 1 runs STEP_DIV=4. Each instance drives its own behavioural
// subtract-based GCD core model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gcd_requester;

    localparam int N = 2;

    logic       clk;
    logic       rst_n;
    logic       i_req      [N];
    logic [7:0] i_x        [N];
    logic [7:0] i_y        [N];
    logic       o_busy     [N];
    logic [7:0] o_result   [N];
    logic       o_valid    [N];
    logic       o_err      [N];
    logic       o_start    [N];
    logic       o_ack      [N];
    logic       o_cen      [N];
    logic       o_core_rst [N];
    logic [7:0] o_ain      [N];
    logic [7:0] o_bin      [N];
    logic       core_i     [N];
    logic       core_done  [N];
    logic [7:0] core_gcd   [N];

    int checks = 0;
    int errors = 0;

    for (genvar k = 0; k < N; k++) begin : g_dut
        gcd_requester #(
            .STEP_DIV      (k == 0 ? 1 : 4),
            .TIMEOUT_STEPS (k == 0 ? 8 : 1023)
        ) u_dut (
            .i_clk          (clk),
            .i_rst_n        (rst_n),
            .i_req          (i_req[k]),
            .i_x_in         (i_x[k]),
            .i_y_in         (i_y[k]),
            .o_busy         (o_busy[k]),
            .o_result       (o_result[k]),
            .o_result_valid (o_valid[k]),
            .o_err          (o_err[k]),
            .o_start        (o_start[k]),
            .o_ack          (o_ack[k]),
            .o_cen          (o_cen[k]),
            .o_core_reset   (o_core_rst[k]),
            .o_ain          (o_ain[k]),
            .o_bin          (o_bin[k]),
            .i_core_i       (core_i[k]),
            .i_core_done    (core_done[k]),
            .i_core_gcd     (core_gcd[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural GCD core: idle -> run (steps on CEN) -> done (waits for ack)
    typedef enum logic [1:0] {C_I, C_RUN, C_DONE} cst_t;
    cst_t       c_state [N];
    logic [7:0] c_a     [N];
    logic [7:0] c_b     [N];
    logic       never_done = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (o_core_rst[k]) begin
                c_state[k] <= C_I;
                c_a[k]     <= 8'd0;
                c_b[k]     <= 8'd0;
            end else begin
                case (c_state[k])
                    C_I: if (o_start[k]) begin
                        c_a[k]     <= o_ain[k];
                        c_b[k]     <= o_bin[k];
                        c_state[k] <= C_RUN;
                    end
                    C_RUN: if (o_cen[k] && !(never_done && k == 0)) begin
                        if (c_a[k] > c_b[k])      c_a[k] <= c_a[k] - c_b[k];
                        else if (c_b[k] > c_a[k]) c_b[k] <= c_b[k] - c_a[k];
                        else                      c_state[k] <= C_DONE;
                    end
                    C_DONE: if (o_ack[k]) c_state[k] <= C_I;
                    default: c_state[k] <= C_I;
                endcase
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            core_i[k]    = (c_state[k] == C_I);
            core_done[k] = (c_state[k] == C_DONE);
            core_gcd[k]  = c_a[k];
        end
    end

    // Event counters sampled on the falling edge
    int valid_cnt [N];
    int start_cnt [N];
    int cen_cnt   [N];
    int crst_cnt  [N];
    int cyc          = 0;
    int last_cen_cyc = -1;
    int cen_gap_bad  = 0;

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (o_valid[k] === 1'b1)    valid_cnt[k]++;
            if (o_start[k] === 1'b1)    start_cnt[k]++;
            if (o_cen[k] === 1'b1)      cen_cnt[k]++;
            if (o_core_rst[k] === 1'b1) crst_cnt[k]++;
        end
        if (o_cen[1] === 1'b1) begin
            if (last_cen_cyc >= 0 && (cyc - last_cen_cyc) != 4) cen_gap_bad++;
            last_cen_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_req(input int k, input logic [7:0] x, input logic [7:0] y);
        @(posedge clk); #1;
        i_req[k] = 1'b1;
        i_x[k]   = x;
        i_y[k]   = y;
        @(posedge clk); #1;
        i_req[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k, input string tag);
        int n = 0;
        @(negedge clk);
        while (o_valid[k] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid_seen"}, 32'(o_valid[k]), 32'd1);
    endtask

    task automatic wait_core_run(input string tag);
        int n = 0;
        @(negedge clk);
        while (c_state[0] != C_RUN && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_core_run"}, 32'(c_state[0] == C_RUN), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, observed no end expected end");
        $fatal(1);
    end

    initial begin
        int v0;
        int s0;
        for (int k = 0; k < N; k++) begin
            i_req[k] = 1'b0;
            i_x[k]   = 8'd0;
            i_y[k]   = 8'd0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy",     32'(o_busy[0]),     32'd0);
        check("rst_result",   32'(o_result[0]),   32'd0);
        check("rst_valid",    32'(o_valid[0]),    32'd0);
        check("rst_err",      32'(o_err[0]),      32'd0);
        check("rst_start",    32'(o_start[0]),    32'd0);
        check("rst_ack",      32'(o_ack[0]),      32'd0);
        check("rst_cen",      32'(o_cen[0]),      32'd0);
        check("rst_core_rst", 32'(o_core_rst[0]), 32'd1);
        check("rst_ain",      32'(o_ain[0]),      32'd0);
        check("rst_bin",      32'(o_bin[0]),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_core_rst", 32'(o_core_rst[0]), 32'd0);

        // gcd(36,24) = 12
        v0 = valid_cnt[0];
        do_req(0, 8'd36, 8'd24);
        wait_valid(0, "g36_24");
        check("g36_24_result", 32'(o_result[0]), 32'd12);
        check("g36_24_err",    32'(o_err[0]),    32'd0);
        check("g36_24_busy",   32'(o_busy[0]),   32'd0);
        @(negedge clk);
        check("g36_24_pulse_end", 32'(o_valid[0]), 32'd0);
        repeat (3) @(negedge clk);
        check("g36_24_one_pulse", 32'(valid_cnt[0] - v0), 32'd1);

        // One zero operand: answered locally, next cycle, no core start
        s0 = start_cnt[0];
        do_req(0, 8'd0, 8'd15);
        @(negedge clk);
        check("z0_15_valid",  32'(o_valid[0]),  32'd1);
        check("z0_15_result", 32'(o_result[0]), 32'd15);
        check("z0_15_err",    32'(o_err[0]),    32'd0);
        check("z0_15_busy",   32'(o_busy[0]),   32'd0);
        repeat (3) @(negedge clk);
        check("z0_15_no_start", 32'(start_cnt[0] - s0), 32'd0);

        // Both zero: Result=0 with Err
        do_req(0, 8'd0, 8'd0);
        @(negedge clk);
        check("z0_0_valid",  32'(o_valid[0]),  32'd1);
        check("z0_0_result", 32'(o_result[0]), 32'd0);
        check("z0_0_err",    32'(o_err[0]),    32'd1);
        repeat (2) @(negedge clk);
        check("z0_0_err_sticky", 32'(o_err[0]), 32'd1);

        // STEP_DIV=4: gcd(9,6)=3, CEN 1 of every 4 cycles
        do_req(1, 8'd9, 8'd6);
        wait_valid(1, "d4_9_6");
        check("d4_9_6_result",  32'(o_result[1]), 32'd3);
        check("d4_9_6_cen_cnt", 32'(cen_cnt[1]),  32'd3);
        check("d4_9_6_cen_gap", 32'(cen_gap_bad), 32'd0);

        // Second request during RUN of (48,18) is ignored
        v0 = valid_cnt[0];
        do_req(0, 8'd48, 8'd18);
        wait_core_run("g48_18");
        do_req(0, 8'd7, 8'd7);
        check("g48_18_ain_held", 32'(o_ain[0]), 32'd48);
        wait_valid(0, "g48_18");
        check("g48_18_result", 32'(o_result[0]), 32'd6);
        check("g48_18_err_clr", 32'(o_err[0]),   32'd0);
        repeat (10) @(negedge clk);
        check("g48_18_one_pulse", 32'(valid_cnt[0] - v0), 32'd1);
        check("g48_18_busy",      32'(o_busy[0]),         32'd0);

        // Asynchronous reset during RUN of (200,150)
        do_req(0, 8'd200, 8'd150);
        wait_core_run("r200");
        @(negedge clk);
        check("r200_in_run_cen", 32'(o_cen[0]), 32'd1);
        v0 = valid_cnt[0];
        #2;
        rst_n = 1'b0;
        #1;
        check("r200_busy",     32'(o_busy[0]),     32'd0);
        check("r200_result",   32'(o_result[0]),   32'd0);
        check("r200_cen",      32'(o_cen[0]),      32'd0);
        check("r200_ack",      32'(o_ack[0]),      32'd0);
        check("r200_core_rst", 32'(o_core_rst[0]), 32'd1);
        check("r200_ain",      32'(o_ain[0]),      32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("r200_no_valid",   32'(valid_cnt[0] - v0), 32'd0);
        check("r200_result_rel", 32'(o_result[0]),       32'd0);
        do_req(0, 8'd200, 8'd150);
        wait_valid(0, "g200_150");
        check("g200_150_result", 32'(o_result[0]), 32'd50);

`ifdef GCD_REQ_TIMEOUT_EN
        // Core never finishes: abort after 8 CEN pulses
        repeat (3) @(negedge clk);
        never_done  = 1'b1;
        cen_cnt[0]  = 0;
        crst_cnt[0] = 0;
        do_req(0, 8'd5, 8'd3);
        wait_valid(0, "tmo");
        check("tmo_err",    32'(o_err[0]),    32'd1);
        check("tmo_result", 32'(o_result[0]), 32'd0);
        check("tmo_busy",   32'(o_busy[0]),   32'd0);
        @(negedge clk);
        check("tmo_cen_cnt",  32'(cen_cnt[0]),  32'd8);
        check("tmo_core_rst", 32'(crst_cnt[0]), 32'd1);
        never_done = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_requester.md
GCD_REQUESTER -- requirements
Module: gcd_requester

Interface
REQ-001 Parameter STEP_DIV, 1, core step period in Clk cycles (1..255); CEN pulses once per STEP_DIV cycles.
REQ-002 Parameter TIMEOUT_STEPS, 1023, max CEN pulses allowed in RUN (used only with GCD_REQ_TIMEOUT_EN).
REQ-003 Clk  in  1  sole clock, all state on rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 Req  in  1  user request, sampled in IDLE only.
REQ-006 X_in, Y_in  in  8 each  operands, captured when Req accepted.
REQ-007 Busy  out  1  high in every state except IDLE.
REQ-008 Result  out  8  last GCD, held until next completion.
REQ-009 Result_valid  out  1  one-cycle pulse per completed request.
REQ-010 Err  out  1  sticky error, cleared on next accepted Req.
REQ-011 Start, Ack, CEN, Core_Reset  out  1 each  drive GCD core (Core_Reset active-high).
REQ-012 Ain, Bin  out  8 each  core operands.
REQ-013 Core_I, Core_Done  in  1 each  core state flags; Core_GCD  in  8  core result.

Function
REQ-014 States: IDLE, ARM, START, RUN, ACK; one-hot, illegal encoding returns to IDLE next cycle.
REQ-015 IDLE: Req=1 with X_in!=0 and Y_in!=0 -> latch operands to Ain/Bin, clear Err, go ARM.
REQ-016 IDLE: Req=1 with X_in or Y_in zero -> no core access; Result<=X_in|Y_in, Result_valid pulse next cycle, Err<=1 only if both zero; stay IDLE.
REQ-017 ARM: wait for Core_I=1, then go START; Ain/Bin stable from ARM until leaving RUN.
REQ-018 START: Start=1; hold until Core_I=0 observed, then go RUN; Start=0 in all other states.
REQ-019 RUN: CEN pulses per STEP_DIV (STEP_DIV=1 -> CEN constantly 1); CEN=0 outside RUN; divider restarts on RUN entry.
REQ-020 RUN: Core_Done=1 -> Result<=Core_GCD same edge, go ACK; CEN forced 0 that cycle.
REQ-021 ACK: Ack=1; hold until Core_I=1 observed, then Result_valid pulse one cycle, go IDLE.
REQ-022 Req while Busy=1 ignored, not queued.
REQ-023 Min latency, STEP_DIV=1, core ready: Req edge to Result_valid = core SUB/MULT steps + 4 cycles.
REQ-024 Result_valid and Err registered; no combinational path from any input to any output.

Reset
REQ-025 Reset=0 -> IDLE, Ain=Bin=Result=0, Result_valid=Err=Start=Ack=CEN=0, counters 0, immediately.
REQ-026 Core_Reset=1 while Reset=0 (core held in reset with requester).
REQ-027 Reset mid-RUN/ACK: transaction discarded, no Result_valid, Result=0 after release.

Configuration
REQ-028 Macro GCD_REQ_TIMEOUT_EN defined: RUN counts CEN pulses; count reaching TIMEOUT_STEPS without Core_Done -> Core_Reset pulse 1 cycle, Result<=0, Err<=1, Result_valid pulse, go IDLE.
REQ-029 Macro undefined: no step counter, RUN waits indefinitely, Core_Reset driven only by REQ-026.

Verification
REQ-030 Req with X_in=36, Y_in=24, behavioural core -> Result=12, one Result_valid pulse, Err=0, Busy low after.
REQ-031 Req with X_in=0, Y_in=15 -> Start never asserted, Result=15, Result_valid next cycle, Err=0; X_in=Y_in=0 -> Result=0, Err=1.
REQ-032 STEP_DIV=4, X_in=9, Y_in=6 -> CEN high exactly 1 of every 4 cycles in RUN, Result=3.
REQ-033 GCD_REQ_TIMEOUT_EN, TIMEOUT_STEPS=8, core model never raises Core_Done -> Core_Reset pulse after 8th CEN, Err=1, Result=0, back to IDLE.
REQ-034 Reset=0 asserted during RUN of (200,150) -> outputs at reset values asynchronously, no Result_valid; next Req (200,150) -> Result=50.
REQ-035 Req pulsed again during RUN of (48,18) -> ignored, exactly one Result_valid, Result=6.
